// File: rtl/mode_arbiter_pkg.sv
// Shared definitions for the mode arbiter: FSM states, owner encodings and parameter defaults.
package mode_arbiter_pkg;

  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
    DRAIN    = 2'd1,
    BLANK    = 2'd2,
    HANDOVER = 2'd3
  } state_t;

  localparam int          TIMER_W           = 16;
  localparam logic        OWNER_ENC         = 1'b0;
  localparam logic        OWNER_DEC         = 1'b1;
  localparam logic [15:0] DEF_DRAIN_TIMEOUT = 16'd50000;
  localparam logic [15:0] DEF_BLANK_CYCLES  = 16'd25000;
  localparam logic [63:0] DEF_BLANK_PATTERN = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mode_arbiter_cycle_timer.sv
// Free-running cycle counter with synchronous clear and a terminal-count compare.
module cycle_timer
  import mode_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [TIMER_W-1:0] terminal,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == terminal);

endmodule

// File: rtl/mode_arbiter.sv
// Grants keypad, backspace and display to the encoder or decoder and sequences mode changes.
// Optional KEY_BUFFER_EN: hold the first key seen during a switch and replay it to the new owner.
module mode_arbiter
  import mode_arbiter_pkg::*;
#(
  parameter logic [15:0] DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter logic [15:0] BLANK_CYCLES  = DEF_BLANK_CYCLES,
  parameter logic [63:0] BLANK_PATTERN = DEF_BLANK_PATTERN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_req,
  input  logic        key_flag,
  input  logic [3:0]  key_value,
  input  logic        bksp,
  input  logic        enc_busy,
  input  logic        dec_busy,
  input  logic [63:0] enc_seg,
  input  logic [63:0] dec_seg,
  output logic        mode,
  output logic        enc_key_flag,
  output logic        dec_key_flag,
  output logic [3:0]  key_value_o,
  output logic        enc_bksp,
  output logic        dec_bksp,
  output logic        enc_clr,
  output logic        dec_clr,
  output logic        abort,
  output logic [63:0] seg_frame,
  output logic        switching,
  output state_t      state
);

  // Handshake: all strobes are single-cycle pulses with no ready/backpressure;
  // a consumer must accept a strobe in the cycle it is high.

  state_t       state_q, state_d;
  logic         mode_d;
  logic         enc_clr_d, dec_clr_d, abort_d;
  logic         owner_busy;
  logic         timer_done;
  logic [15:0]  terminal;
  logic         route_key, route_bksp;
  logic [3:0]   route_value;
  logic         buf_valid;
  logic [3:0]   buf_value;

  assign state      = state_q;
  assign switching  = (state_q != ACTIVE);
  assign owner_busy = (mode == OWNER_DEC) ? dec_busy : enc_busy;
  assign seg_frame  = (state_q == ACTIVE || state_q == DRAIN)
                      ? ((mode == OWNER_DEC) ? dec_seg : enc_seg)
                      : BLANK_PATTERN;

  always_comb begin
    terminal = '0;
    case (state_q)
      DRAIN:   terminal = DRAIN_TIMEOUT - 16'd1;
      BLANK:   terminal = BLANK_CYCLES - 16'd1;
      default: terminal = '0;
    endcase
  end

  cycle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_d != state_q),
    .en       (state_q != ACTIVE),
    .terminal (terminal),
    .done     (timer_done)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode;
    enc_clr_d = 1'b0;
    dec_clr_d = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      ACTIVE: begin
        if (mode_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!owner_busy) begin
          state_d = BLANK;
        end else if (timer_done) begin
          // Owner never went idle: force the switch and clear the old owner.
          state_d = BLANK;
          abort_d = 1'b1;
          if (mode == OWNER_DEC) dec_clr_d = 1'b1;
          else                   enc_clr_d = 1'b1;
        end
      end
      BLANK: begin
        if (timer_done) begin
          state_d = HANDOVER;
          mode_d  = ~mode;
          if (mode == OWNER_ENC) dec_clr_d = 1'b1;
          else                   enc_clr_d = 1'b1;
        end
      end
      HANDOVER: state_d = ACTIVE;
      default:  state_d = ACTIVE;
    endcase
  end

`ifdef KEY_BUFFER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_value <= '0;
    end else if (state_q == ACTIVE) begin
      buf_valid <= 1'b0;
    end else if (key_flag && !buf_valid) begin
      buf_valid <= 1'b1;
      buf_value <= key_value;
    end
  end
`else
  assign buf_valid = 1'b0;
  assign buf_value = 4'd0;
`endif

  // A pending replay wins the first ACTIVE cycle so it lands after the clr.
  always_comb begin
    route_key   = 1'b0;
    route_value = key_value;
    route_bksp  = 1'b0;
    if (state_q == ACTIVE) begin
      route_bksp = bksp;
      if (buf_valid) begin
        route_key   = 1'b1;
        route_value = buf_value;
      end else begin
        route_key = key_flag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACTIVE;
      mode         <= OWNER_ENC;
      enc_key_flag <= 1'b0;
      dec_key_flag <= 1'b0;
      key_value_o  <= '0;
      enc_bksp     <= 1'b0;
      dec_bksp     <= 1'b0;
      enc_clr      <= 1'b0;
      dec_clr      <= 1'b0;
      abort        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode         <= mode_d;
      enc_key_flag <= route_key && (mode == OWNER_ENC);
      dec_key_flag <= route_key && (mode == OWNER_DEC);
      enc_bksp     <= route_bksp && (mode == OWNER_ENC);
      dec_bksp     <= route_bksp && (mode == OWNER_DEC);
      enc_clr      <= enc_clr_d;
      dec_clr      <= dec_clr_d;
      abort        <= abort_d;
      if (route_key) key_value_o <= route_value;
    end
  end

endmodule

// File: tb/tb_mode_arbiter.sv
// Self-checking bench for mode_arbiter: directed scenarios plus randomized traffic against a timeline model.
module tb_mode_arbiter;
  import mode_arbiter_pkg::*;

  localparam int DT = 8;
  localparam int BC = 4;
`ifdef KEY_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, mode_req, key_flag, bksp, enc_busy, dec_busy;
  logic [3:0]  key_value;
  logic [63:0] enc_seg, dec_seg;
  logic        mode, enc_key_flag, dec_key_flag, enc_bksp, dec_bksp;
  logic        enc_clr, dec_clr, abort, switching;
  logic [3:0]  key_value_o;
  logic [63:0] seg_frame;
  state_t      state;

  int checks = 0;
  int errors = 0;

  mode_arbiter #(.DRAIN_TIMEOUT(16'd8), .BLANK_CYCLES(16'd4)) dut (
    .clk(clk), .rst(rst), .mode_req(mode_req), .key_flag(key_flag), .key_value(key_value),
    .bksp(bksp), .enc_busy(enc_busy), .dec_busy(dec_busy), .enc_seg(enc_seg), .dec_seg(dec_seg),
    .mode(mode), .enc_key_flag(enc_key_flag), .dec_key_flag(dec_key_flag),
    .key_value_o(key_value_o), .enc_bksp(enc_bksp), .dec_bksp(dec_bksp), .enc_clr(enc_clr),
    .dec_clr(dec_clr), .abort(abort), .seg_frame(seg_frame), .switching(switching), .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Switch timeline: k is the cycle index since the switch began (0 = first drain
  // cycle); drain_len is 0 until the drain outcome is known.
  bit         model_ok = 1'b0;
  bit         m_mode, in_sw, buf_v, m_busy, rk;
  int         k, drain_len;
  logic [3:0] buf_val, rv;
  logic       e_enc_key, e_dec_key, e_enc_bksp, e_dec_bksp, e_enc_clr, e_dec_clr, e_abort;
  logic [3:0] e_kv;
  state_t     e_state;

  always @(posedge clk) begin
    if (rst) begin
      model_ok = 1'b1; m_mode = 1'b0; in_sw = 1'b0; k = 0; drain_len = 0;
      buf_v = 1'b0; buf_val = '0; e_kv = '0;
      {e_enc_key, e_dec_key, e_enc_bksp, e_dec_bksp, e_enc_clr, e_dec_clr, e_abort} = '0;
    end else if (model_ok) begin
      {e_enc_key, e_dec_key, e_enc_bksp, e_dec_bksp, e_enc_clr, e_dec_clr, e_abort} = '0;
      if (!in_sw) begin
        rk = 1'b0; rv = key_value;
        if (BUF_EN && buf_v) begin rk = 1'b1; rv = buf_val; buf_v = 1'b0; end
        else if (key_flag) rk = 1'b1;
        if (rk) begin
          e_kv = rv;
          if (m_mode) e_dec_key = 1'b1; else e_enc_key = 1'b1;
        end
        if (bksp) begin
          if (m_mode) e_dec_bksp = 1'b1; else e_enc_bksp = 1'b1;
        end
        if (mode_req) begin in_sw = 1'b1; k = 0; drain_len = 0; end
      end else begin
        m_busy = m_mode ? dec_busy : enc_busy;
        if (BUF_EN && key_flag && !buf_v) begin buf_v = 1'b1; buf_val = key_value; end
        if (drain_len == 0) begin
          if (!m_busy) drain_len = k + 1;
          else if (k == DT - 1) begin
            drain_len = k + 1; e_abort = 1'b1;
            if (m_mode) e_dec_clr = 1'b1; else e_enc_clr = 1'b1;
          end
        end else if (k == drain_len + BC - 1) begin
          m_mode = !m_mode;
          if (m_mode) e_dec_clr = 1'b1; else e_enc_clr = 1'b1;
        end else if (k == drain_len + BC) begin
          in_sw = 1'b0;
        end
        k++;
      end
    end
    #1;
    if (model_ok) begin
      if (!in_sw)                  e_state = ACTIVE;
      else if (drain_len == 0)     e_state = DRAIN;
      else if (k < drain_len + BC) e_state = BLANK;
      else                         e_state = HANDOVER;
      chk("m_state", 64'(state), 64'(e_state));
      chk("m_mode", 64'(mode), 64'(m_mode));
      chk("m_switching", 64'(switching), 64'(in_sw));
      chk("m_enc_key", 64'(enc_key_flag), 64'(e_enc_key));
      chk("m_dec_key", 64'(dec_key_flag), 64'(e_dec_key));
      chk("m_key_value", 64'(key_value_o), 64'(e_kv));
      chk("m_enc_bksp", 64'(enc_bksp), 64'(e_enc_bksp));
      chk("m_dec_bksp", 64'(dec_bksp), 64'(e_dec_bksp));
      chk("m_enc_clr", 64'(enc_clr), 64'(e_enc_clr));
      chk("m_dec_clr", 64'(dec_clr), 64'(e_dec_clr));
      chk("m_abort", 64'(abort), 64'(e_abort));
      chk("m_seg", seg_frame,
          (!in_sw || drain_len == 0) ? (m_mode ? dec_seg : enc_seg) : DEF_BLANK_PATTERN);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input state_t target, input int limit, input string name);
    int n;
    n = 0;
    while (state !== target && n < limit) begin
      tick();
      n++;
    end
    chk(name, 64'(state), 64'(target));
  endtask

  task automatic do_switch(input string name);
    mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    wait_state(ACTIVE, 40, name);
  endtask

  // ---------------- stimulus ----------------
  int sw, blk, ho, dcnt, fires, fire_idx, enc_fires;
  logic [3:0] fire_val;

  initial begin
    rst = 1'b1; mode_req = 1'b0; key_flag = 1'b0; key_value = '0; bksp = 1'b0;
    enc_busy = 1'b0; dec_busy = 1'b0;
    enc_seg = 64'h0123_4567_89AB_CDEF; dec_seg = 64'hFEDC_BA98_7654_3210;
    tick(); tick();
    chk("rst_mode", 64'(mode), 64'd0);
    chk("rst_state", 64'(state), 64'(ACTIVE));
    chk("rst_switching", 64'(switching), 64'd0);
    chk("rst_key_value", 64'(key_value_o), 64'd0);
    chk("rst_strobes", 64'({enc_key_flag, dec_key_flag, enc_bksp, dec_bksp, enc_clr, dec_clr, abort}), 64'd0);
    rst = 1'b0;

    // Key routed to the encoder one cycle later, single cycle wide.
    key_flag = 1'b1; key_value = 4'h5;
    tick();
    key_flag = 1'b0;
    chk("t1_enc_key", 64'(enc_key_flag), 64'd1);
    chk("t1_dec_key", 64'(dec_key_flag), 64'd0);
    chk("t1_key_value", 64'(key_value_o), 64'h5);
    chk("t1_seg", seg_frame, 64'h0123_4567_89AB_CDEF);
    tick();
    chk("t1_width", 64'(enc_key_flag), 64'd0);

    // Clean switch: 1 drain + 4 blank + 1 handover.
    mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    chk("t2_drain", 64'(state), 64'(DRAIN));
    sw = 0; blk = 0; ho = 0;
    for (int n = 0; n < 20 && switching; n++) begin
      sw++;
      if (state == BLANK && seg_frame == 64'hFFFF_FFFF_FFFF_FFFF) blk++;
      if (state == HANDOVER && dec_clr && mode) ho++;
      tick();
    end
    chk("t2_switch_cycles", 64'(sw), 64'd6);
    chk("t2_blank_cycles", 64'(blk), 64'd4);
    chk("t2_handover", 64'(ho), 64'd1);
    chk("t2_mode", 64'(mode), 64'd1);

    // Drain timeout with the encoder stuck busy.
    do_switch("t3_back_to_enc");
    enc_busy = 1'b1;
    mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    dcnt = 0;
    while (state == DRAIN && dcnt < 30) begin
      dcnt++;
      tick();
    end
    chk("t3_drain_cycles", 64'(dcnt), 64'd8);
    chk("t3_abort", 64'(abort), 64'd1);
    chk("t3_enc_clr", 64'(enc_clr), 64'd1);
    chk("t3_dec_clr", 64'(dec_clr), 64'd0);
    chk("t3_blank", 64'(state), 64'(BLANK));
    enc_busy = 1'b0;
    wait_state(ACTIVE, 20, "t3_done");

    // Keys during blanking: only the first may be replayed.
    do_switch("t4_back_to_enc");
    mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    wait_state(BLANK, 20, "t4_reach_blank");
    key_flag = 1'b1; key_value = 4'h3;
    tick();
    key_value = 4'h7;
    tick();
    key_flag = 1'b0;
    wait_state(ACTIVE, 20, "t4_reach_active");
    fires = 0; fire_idx = 0; fire_val = '0; enc_fires = 0;
    for (int i = 1; i <= 5; i++) begin
      if (dec_key_flag) begin fires++; fire_idx = i; fire_val = key_value_o; end
      if (enc_key_flag) enc_fires++;
      tick();
    end
    chk("t4_fires", 64'(fires), BUF_EN ? 64'd1 : 64'd0);
    chk("t4_fire_cycle", 64'(fire_idx), BUF_EN ? 64'd2 : 64'd0);
    chk("t4_fire_value", 64'(fire_val), BUF_EN ? 64'd3 : 64'd0);
    chk("t4_enc_fires", 64'(enc_fires), 64'd0);

    // Key with mode_req goes to old owner; second request while blanking ignored.
    mode_req = 1'b1; key_flag = 1'b1; key_value = 4'h9;
    tick();
    mode_req = 1'b0; key_flag = 1'b0;
    chk("t5_dec_key", 64'(dec_key_flag), 64'd1);
    chk("t5_enc_key", 64'(enc_key_flag), 64'd0);
    chk("t5_key_value", 64'(key_value_o), 64'h9);
    chk("t5_drain", 64'(state), 64'(DRAIN));
    wait_state(BLANK, 20, "t5_reach_blank");
    mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    wait_state(ACTIVE, 20, "t5_reach_active");
    chk("t5_mode", 64'(mode), 64'd0);
    tick(); tick(); tick();
    chk("t5_no_second_toggle", 64'(switching), 64'd0);

    // Reset in the middle of blanking.
    do_switch("t6_to_dec");
    mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    wait_state(BLANK, 20, "t6_reach_blank");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_mode", 64'(mode), 64'd0);
    chk("t6_state", 64'(state), 64'(ACTIVE));
    chk("t6_switching", 64'(switching), 64'd0);
    chk("t6_seg", seg_frame, enc_seg);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst       = ($urandom_range(0, 399) == 0);
      mode_req  = ($urandom_range(0, 24) == 0);
      key_flag  = ($urandom_range(0, 3) == 0);
      key_value = 4'($urandom_range(0, 15));
      bksp      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) enc_busy = ~enc_busy;
      if ($urandom_range(0, 7) == 0) dec_busy = ~dec_busy;
      if ($urandom_range(0, 49) == 0) enc_seg = {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) dec_seg = {$urandom, $urandom};
    end
    rst = 1'b0; mode_req = 1'b0; key_flag = 1'b0; bksp = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
